// File: rtl/alarm_match_unit.sv
// alarm_match_unit: per-channel time-compare alarms, each with a ringing/ack state machine.
// Optional snooze state and per-channel tick countdown are built when ALARM_SNOOZE_EN is defined.
module alarm_match_unit #(
    parameter int WIDTH        = 6,
    parameter int CHANNELS     = 4,
    parameter int SNOOZE_TICKS = 5,
    parameter int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  tick,
    input  logic [WIDTH-1:0]      time_val,
    input  logic                  cfg_we,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic [WIDTH-1:0]      cfg_val,
    input  logic                  cfg_en,
    input  logic [CHANNELS-1:0]   ack,
`ifdef ALARM_SNOOZE_EN
    input  logic [CHANNELS-1:0]   snooze,
`endif
    output logic [CHANNELS-1:0]   match_pulse,
    output logic [CHANNELS-1:0]   ringing,
    output logic                  any_ringing,
    output logic [2*CHANNELS-1:0] state_dbg
);
    // Strobes (tick, cfg_we, ack, snooze) are single-cycle, sampled on the rising edge with no
    // back-pressure; a cfg_we to a channel overrides every other event on that channel that cycle.

    typedef enum logic [1:0] {IDLE = 2'd0, RINGING = 2'd1, SNOOZE = 2'd2, DONE = 2'd3} state_t;

    if (CHANNELS < 1 || SNOOZE_TICKS < 1) begin : g_bad_param
        $error("alarm_match_unit: CHANNELS and SNOOZE_TICKS must be >= 1");
    end

    logic [WIDTH-1:0]    value_q [CHANNELS];
    logic [CHANNELS-1:0] en_q;
    state_t              state_q [CHANNELS];
    state_t              state_d [CHANNELS];
    logic [CHANNELS-1:0] pulse_d;
    logic [CHANNELS-1:0] wr;
    logic [CHANNELS-1:0] eq;

`ifdef ALARM_SNOOZE_EN
    localparam int CNT_W = $clog2(SNOOZE_TICKS + 1);
    logic [CNT_W-1:0] cnt_q [CHANNELS];
    logic [CNT_W-1:0] cnt_d [CHANNELS];
`endif

    always_comb begin
        wr = '0;
        eq = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wr[i] = cfg_we && (cfg_ch == CH_W'(i));
            eq[i] = en_q[i] && (time_val == value_q[i]);
        end
    end

    always_comb begin
        pulse_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
`ifdef ALARM_SNOOZE_EN
            cnt_d[i] = cnt_q[i];
`endif
            if (wr[i]) begin
                state_d[i] = IDLE;
`ifdef ALARM_SNOOZE_EN
                cnt_d[i] = '0;
`endif
            end else begin
                case (state_q[i])
                    IDLE: begin
                        if (tick && eq[i]) begin
                            state_d[i] = RINGING;
                            pulse_d[i] = 1'b1;
                        end
                    end
                    RINGING: begin
                        if (ack[i]) begin
                            state_d[i] = DONE;
                        end
`ifdef ALARM_SNOOZE_EN
                        else if (snooze[i]) begin
                            state_d[i] = SNOOZE;
                            cnt_d[i]   = CNT_W'(SNOOZE_TICKS);
                        end
`endif
                    end
`ifdef ALARM_SNOOZE_EN
                    SNOOZE: begin
                        if (ack[i]) begin
                            state_d[i] = DONE;
                        end else if (tick) begin
                            if (cnt_q[i] == CNT_W'(1)) begin
                                state_d[i] = RINGING;
                                pulse_d[i] = 1'b1;
                            end else begin
                                cnt_d[i] = cnt_q[i] - CNT_W'(1);
                            end
                        end
                    end
`endif
                    DONE: begin
                        // Hold off re-triggering until the time has moved off the match value.
                        if (tick && !eq[i]) begin
                            state_d[i] = IDLE;
                        end
                    end
                    default: state_d[i] = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                value_q[i] <= '0;
                state_q[i] <= IDLE;
            end
            en_q        <= '0;
            match_pulse <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                if (wr[i]) begin
                    value_q[i] <= cfg_val;
                    en_q[i]    <= cfg_en;
                end
            end
            match_pulse <= pulse_d;
        end
    end

`ifdef ALARM_SNOOZE_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`endif

    always_comb begin
        ringing   = '0;
        state_dbg = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            ringing[i]          = (state_q[i] == RINGING);
            state_dbg[2*i +: 2] = state_q[i];
        end
    end

    assign any_ringing = |ringing;

endmodule

// File: tb/tb_alarm_match_unit.sv
// Self-checking bench for alarm_match_unit (3 channels, 6-bit time); snooze cases
// are exercised only when ALARM_SNOOZE_EN is defined.
module tb_alarm_match_unit;

  localparam int W  = 6;
  localparam int CH = 3;
  localparam int CW = 2;

  logic          clk;
  logic          reset_n;
  logic          tick;
  logic [W-1:0]  time_val;
  logic          cfg_we;
  logic [CW-1:0] cfg_ch;
  logic [W-1:0]  cfg_val;
  logic          cfg_en;
  logic [CH-1:0] ack;
  logic [CH-1:0] snooze;
  logic [CH-1:0] match_pulse;
  logic [CH-1:0] ringing;
  logic          any_ringing;
  logic [2*CH-1:0] state_dbg;

  int check_cnt = 0;
  int pass_cnt  = 0;

  // {any_ringing, match_pulse, ringing}
  logic [2*CH:0] exp_q[$];

  alarm_match_unit #(
    .WIDTH(W), .CHANNELS(CH), .SNOOZE_TICKS(3), .CH_W(CW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .tick(tick),
    .time_val(time_val),
    .cfg_we(cfg_we),
    .cfg_ch(cfg_ch),
    .cfg_val(cfg_val),
    .cfg_en(cfg_en),
    .ack(ack),
`ifdef ALARM_SNOOZE_EN
    .snooze(snooze),
`endif
    .match_pulse(match_pulse),
    .ringing(ringing),
    .any_ringing(any_ringing),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle_inputs();
    tick = 1'b0; time_val = '0; cfg_we = 1'b0; cfg_ch = '0;
    cfg_val = '0; cfg_en = 1'b0; ack = '0; snooze = '0;
  endtask

  // Drive one cycle of stimulus, push its expected outcome, clock it and score it.
  task automatic drive(input string tag, input logic we, input logic [CW-1:0] ch,
                       input logic [W-1:0] val, input logic en, input logic t,
                       input logic [W-1:0] tv, input logic [CH-1:0] a,
                       input logic [CH-1:0] sn, input logic [CH-1:0] ep,
                       input logic [CH-1:0] er);
    logic [2*CH:0] e;
    cfg_we = we; cfg_ch = ch; cfg_val = val; cfg_en = en;
    tick = t; time_val = tv; ack = a; snooze = sn;
    exp_q.push_back({|er, ep, er});
    @(posedge clk);
    #1;
    idle_inputs();
    e = exp_q.pop_front();
    check(tag, {25'd0, any_ringing, match_pulse, ringing}, {25'd0, e});
  endtask

  task automatic cfg(input string tag, input logic [CW-1:0] ch, input logic [W-1:0] val,
                     input logic en, input logic [CH-1:0] er);
    drive(tag, 1'b1, ch, val, en, 1'b0, '0, '0, '0, '0, er);
  endtask

  task automatic tk(input string tag, input logic [W-1:0] tv, input logic [CH-1:0] ep,
                    input logic [CH-1:0] er);
    drive(tag, 1'b0, '0, '0, 1'b0, 1'b1, tv, '0, '0, ep, er);
  endtask

  task automatic ack_ch(input string tag, input logic [CH-1:0] a, input logic [CH-1:0] er);
    drive(tag, 1'b0, '0, '0, 1'b0, 1'b0, '0, a, '0, '0, er);
  endtask

  initial begin
    int mst;
    logic t;
    logic [W-1:0] tv;
    logic a;
    logic ep;

    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {ringing, match_pulse, any_ringing}, '0);
    check("reset_state", state_dbg, '0);
    reset_n = 1'b1;

    // single-channel match, no re-trigger while matching
    cfg("cfg_ch0_37", 2'd0, 6'd37, 1'b1, 3'b000);
    tk("first_match", 6'd37, 3'b001, 3'b001);
    for (int i = 0; i < 3; i++) tk("hold_match", 6'd37, 3'b000, 3'b001);
    drive("no_tick", 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, '0, '0, 3'b001);
    ack_ch("ack_ch0", 3'b001, 3'b000);
    tk("done_silent_a", 6'd37, 3'b000, 3'b000);
    tk("done_silent_b", 6'd37, 3'b000, 3'b000);
    tk("move_off", 6'd38, 3'b000, 3'b000);
    tk("rematch", 6'd37, 3'b001, 3'b001);
    ack_ch("ack_ch0_b", 3'b001, 3'b000);

    // simultaneous matches, disabled channel stays silent
    cfg("cfg_ch1_12", 2'd1, 6'd12, 1'b1, 3'b000);
    cfg("cfg_ch2_12", 2'd2, 6'd12, 1'b1, 3'b000);
    cfg("cfg_ch0_off", 2'd0, 6'd12, 1'b0, 3'b000);
    tk("multi_match", 6'd12, 3'b110, 3'b110);
    tk("multi_hold", 6'd12, 3'b000, 3'b110);
    ack_ch("multi_ack", 3'b110, 3'b000);
    ack_ch("ack_in_done", 3'b111, 3'b000);

`ifdef ALARM_SNOOZE_EN
    cfg("cfg_ch0_5", 2'd0, 6'd5, 1'b1, 3'b000);
    tk("snz_match", 6'd5, 3'b001, 3'b001);
    drive("snz_enter", 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 3'b001, '0, 3'b000);
    tk("snz_tick1", 6'd5, 3'b000, 3'b000);
    drive("snz_notick", 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, '0, '0, 3'b000);
    tk("snz_tick2", 6'd5, 3'b000, 3'b000);
    tk("snz_rering", 6'd5, 3'b001, 3'b001);
    drive("ack_snz_same", 1'b0, '0, '0, 1'b0, 1'b0, '0, 3'b001, 3'b001, '0, 3'b000);
    for (int i = 0; i < 4; i++) tk("ack_wins_quiet", 6'd5, 3'b000, 3'b000);
`endif

    // config write while ringing, out-of-range channel write
    cfg("cfg_ch0_40", 2'd0, 6'd40, 1'b1, 3'b000);
    tk("match_40", 6'd40, 3'b001, 3'b001);
    drive("cfg_while_ring", 1'b1, 2'd0, 6'd20, 1'b1, 1'b1, 6'd20, 3'b001, '0, '0, 3'b000);
    tk("match_20", 6'd20, 3'b001, 3'b001);
    cfg("cfg_bad_ch", 2'd3, 6'd0, 1'b0, 3'b001);
    tk("bad_ch_no_effect", 6'd20, 3'b000, 3'b001);

    // asynchronous reset mid-ringing
    reset_n = 1'b0;
    #1;
    check("async_reset_out", {ringing, match_pulse, any_ringing}, '0);
    check("async_reset_state", state_dbg, '0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tk("post_reset_disabled", 6'd20, 3'b000, 3'b000);

    // randomized single-channel traffic against a reference model (0 idle, 1 ring, 2 done)
    cfg("cfg_ch1_2", 2'd1, 6'd2, 1'b1, 3'b000);
    mst = 0;
    for (int i = 0; i < 60; i++) begin
      t  = 1'($urandom_range(0, 1));
      tv = 6'($urandom_range(0, 3));
      a  = ($urandom_range(0, 3) == 0);
      ep = 1'b0;
      case (mst)
        0: if (t && tv == 6'd2) begin mst = 1; ep = 1'b1; end
        1: if (a) mst = 2;
        default: if (t && tv != 6'd2) mst = 0;
      endcase
      drive("rand_ch1", 1'b0, '0, '0, 1'b0, t, tv, {1'b0, a, 1'b0}, '0,
            {1'b0, ep, 1'b0}, {1'b0, (mst == 1), 1'b0});
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
